// File: rtl/regfile_arbiter_pkg.sv
// Shared types for the register-file arbiter: register-file op and select encodings,
// arbiter FSM states and the latched command record.
package regfile_arbiter_pkg;

    localparam int REGARB_DATA_W = 8;

    typedef enum logic [1:0] {
        REG_OP_NOP   = 2'd0,
        REG_OP_READ  = 2'd1,
        REG_OP_WRITE = 2'd2,
        REG_OP_ADD   = 2'd3
    } registers_op_e;

    typedef enum logic [1:0] {
        REG_R0 = 2'd0,
        REG_R1 = 2'd1,
        REG_R2 = 2'd2,
        REG_R3 = 2'd3
    } register_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } regarb_state_e;

    typedef struct packed {
        registers_op_e            op;
        register_sel_e            sel1;
        register_sel_e            sel2;
        logic [REGARB_DATA_W-1:0] data;
    } regfile_cmd_t;

endpackage

// File: rtl/regfile_arbiter_rr_arbiter2.sv
// Two-way grant decision: round-robin on last_grant, or req0 priority with a
// starvation counter that forces req1 after STARVE_LIMIT back-to-back req0 wins.
module rr_arbiter2 #(
    parameter int FIXED_PRIO   = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_req0_valid,
    input  logic i_req1_valid,
    output logic o_grant_valid,
    output logic o_grant_id
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    logic          r_last_grant;
    logic [CW-1:0] r_starve_cnt;

    // Grant decision for the current IDLE cycle.
    always_comb begin
        o_grant_valid = i_en && (i_req0_valid || i_req1_valid);
        o_grant_id    = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            if (FIXED_PRIO != 0) begin
                o_grant_id = (r_starve_cnt == LIMIT_C);
            end else begin
                o_grant_id = ~r_last_grant;
            end
        end else if (i_req1_valid) begin
            o_grant_id = 1'b1;
        end else begin
            o_grant_id = 1'b0;
        end
    end

    // History only moves on an actual grant, so a withdrawn request leaves it untouched.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_grant <= 1'b1;
            r_starve_cnt <= {CW{1'b0}};
        end else if (o_grant_valid) begin
            r_last_grant <= o_grant_id;
            if (o_grant_id || !i_req1_valid) begin
                r_starve_cnt <= {CW{1'b0}};
            end else if (r_starve_cnt != LIMIT_C) begin
                r_starve_cnt <= r_starve_cnt + CW'(1);
            end else begin
                r_starve_cnt <= r_starve_cnt;
            end
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares one register-file port between the control unit (req0) and debug host (req1).
// Each accepted command runs IDLE -> EXEC -> RESP and returns both read ports.
module regfile_arbiter
    import regfile_arbiter_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = REGARB_DATA_W,
    parameter int FIXED_PRIO     = 0,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  registers_op_e             req0_op,
    input  register_sel_e             req0_sel1,
    input  register_sel_e             req0_sel2,
    input  logic [DATA_BUS_WIDTH-1:0] req0_data,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  registers_op_e             req1_op,
    input  register_sel_e             req1_sel1,
    input  register_sel_e             req1_sel2,
    input  logic [DATA_BUS_WIDTH-1:0] req1_data,
    output logic                      rsp0_valid,
    output logic [DATA_BUS_WIDTH-1:0] rsp0_data1,
    output logic [DATA_BUS_WIDTH-1:0] rsp0_data2,
    output logic                      rsp1_valid,
    output logic [DATA_BUS_WIDTH-1:0] rsp1_data1,
    output logic [DATA_BUS_WIDTH-1:0] rsp1_data2,
    output registers_op_e             op,
    output register_sel_e             reg_1_out_sel,
    output register_sel_e             reg_2_out_sel,
    output logic [DATA_BUS_WIDTH-1:0] reg_data_in,
    input  logic [DATA_BUS_WIDTH-1:0] reg_1_out,
    input  logic [DATA_BUS_WIDTH-1:0] reg_2_out
);

    regarb_state_e r_state;
    logic          r_grant_id;
    logic          w_arb_en;
    logic          w_grant_valid;
    logic          w_grant_id;
    regfile_cmd_t  w_cmd;

    assign w_arb_en   = (r_state == ST_IDLE) && !reset;
    assign req0_ready = w_arb_en;
    assign req1_ready = w_arb_en;

    rr_arbiter2 #(
        .FIXED_PRIO   (FIXED_PRIO),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .i_clk         (clock),
        .i_reset       (reset),
        .i_en          (w_arb_en),
        .i_req0_valid  (req0_valid),
        .i_req1_valid  (req1_valid),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    // Command offered by whichever requester the arbiter picked.
    always_comb begin
        w_cmd = '0;
        if (w_grant_id) begin
            w_cmd.op   = req1_op;
            w_cmd.sel1 = req1_sel1;
            w_cmd.sel2 = req1_sel2;
            w_cmd.data = REGARB_DATA_W'(req1_data);
        end else begin
            w_cmd.op   = req0_op;
            w_cmd.sel1 = req0_sel1;
            w_cmd.sel2 = req0_sel2;
            w_cmd.data = REGARB_DATA_W'(req0_data);
        end
    end

    // Command FSM; the port outputs double as the command latch, op drops back to NOP after EXEC.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_grant_id    <= 1'b0;
            op            <= REG_OP_NOP;
            reg_1_out_sel <= REG_R0;
            reg_2_out_sel <= REG_R0;
            reg_data_in   <= {DATA_BUS_WIDTH{1'b0}};
            rsp0_valid    <= 1'b0;
            rsp1_valid    <= 1'b0;
            rsp0_data1    <= {DATA_BUS_WIDTH{1'b0}};
            rsp0_data2    <= {DATA_BUS_WIDTH{1'b0}};
            rsp1_data1    <= {DATA_BUS_WIDTH{1'b0}};
            rsp1_data2    <= {DATA_BUS_WIDTH{1'b0}};
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        op            <= w_cmd.op;
                        reg_1_out_sel <= w_cmd.sel1;
                        reg_2_out_sel <= w_cmd.sel2;
                        reg_data_in   <= DATA_BUS_WIDTH'(w_cmd.data);
                        r_grant_id    <= w_grant_id;
                        r_state       <= ST_EXEC;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    // Read ports are sampled on the same edge that commits the write: pre-write values.
                    op      <= REG_OP_NOP;
                    r_state <= ST_RESP;
                    if (r_grant_id) begin
                        rsp1_valid <= 1'b1;
                        rsp1_data1 <= reg_1_out;
                        rsp1_data2 <= reg_2_out;
                    end else begin
                        rsp0_valid <= 1'b1;
                        rsp0_data1 <= reg_1_out;
                        rsp0_data2 <= reg_2_out;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    op      <= REG_OP_NOP;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench: a round-robin and a fixed-priority arbiter share stimulus; each drives its own
// small register file and is checked every cycle against a transaction-level model.
module tb_regfile_arbiter;
    import regfile_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic          v0 = 1'b0, v1 = 1'b0;
    registers_op_e op0 = REG_OP_NOP, op1 = REG_OP_NOP;
    register_sel_e a0 = REG_R0, b0 = REG_R0, a1 = REG_R0, b1 = REG_R0;
    logic [7:0]    wd0 = 8'h00, wd1 = 8'h00;

    logic          rdy0 [2], rdy1 [2], rv0 [2], rv1 [2];
    logic [7:0]    r0d1 [2], r0d2 [2], r1d1 [2], r1d2 [2];
    registers_op_e d_op [2];
    register_sel_e d_s1 [2], d_s2 [2];
    logic [7:0]    d_din [2];
    logic [7:0]    r1o [2], r2o [2];
    logic [7:0]    rf [2][4];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit m_init = 1'b0;
    int log_rr[$];
    int log_fp[$];

    regfile_arbiter #(.DATA_BUS_WIDTH(8), .FIXED_PRIO(0), .STARVE_LIMIT(4)) u_rr (
        .clock(clock), .reset(reset),
        .req0_valid(v0), .req0_ready(rdy0[0]), .req0_op(op0), .req0_sel1(a0), .req0_sel2(b0), .req0_data(wd0),
        .req1_valid(v1), .req1_ready(rdy1[0]), .req1_op(op1), .req1_sel1(a1), .req1_sel2(b1), .req1_data(wd1),
        .rsp0_valid(rv0[0]), .rsp0_data1(r0d1[0]), .rsp0_data2(r0d2[0]),
        .rsp1_valid(rv1[0]), .rsp1_data1(r1d1[0]), .rsp1_data2(r1d2[0]),
        .op(d_op[0]), .reg_1_out_sel(d_s1[0]), .reg_2_out_sel(d_s2[0]), .reg_data_in(d_din[0]),
        .reg_1_out(r1o[0]), .reg_2_out(r2o[0]));

    regfile_arbiter #(.DATA_BUS_WIDTH(8), .FIXED_PRIO(1), .STARVE_LIMIT(4)) u_fp (
        .clock(clock), .reset(reset),
        .req0_valid(v0), .req0_ready(rdy0[1]), .req0_op(op0), .req0_sel1(a0), .req0_sel2(b0), .req0_data(wd0),
        .req1_valid(v1), .req1_ready(rdy1[1]), .req1_op(op1), .req1_sel1(a1), .req1_sel2(b1), .req1_data(wd1),
        .rsp0_valid(rv0[1]), .rsp0_data1(r0d1[1]), .rsp0_data2(r0d2[1]),
        .rsp1_valid(rv1[1]), .rsp1_data1(r1d1[1]), .rsp1_data2(r1d2[1]),
        .op(d_op[1]), .reg_1_out_sel(d_s1[1]), .reg_2_out_sel(d_s2[1]), .reg_data_in(d_din[1]),
        .reg_1_out(r1o[1]), .reg_2_out(r2o[1]));

    // Register files: combinational reads, write/add into sel1, cleared by reset.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            r1o[k] = rf[k][d_s1[k]];
            r2o[k] = rf[k][d_s2[k]];
        end
    end

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int j = 0; j < 4; j++) rf[k][j] <= 8'h00;
            end else if (d_op[k] == REG_OP_WRITE) begin
                rf[k][d_s1[k]] <= d_din[k];
            end else if (d_op[k] == REG_OP_ADD) begin
                rf[k][d_s1[k]] <= rf[k][d_s1[k]] + d_din[k];
            end
        end
    end

    // Transaction-level model: an accepted command occupies the port for three cycles.
    bit            m_busy [2];
    int            m_acc [2];
    int            m_gid [2];
    registers_op_e m_cop [2];
    int            m_cs1 [2], m_cs2 [2];
    logic [7:0]    m_cd [2];
    int            m_last [2], m_starve [2];
    logic [7:0]    m_reg [2][4];
    logic          e_rv [2][2];
    logic [7:0]    e_d1 [2][2], e_d2 [2][2];
    registers_op_e e_op [2];

    always @(posedge clock) begin
        bit was_free;
        int g;
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_busy[k] = 1'b0; m_last[k] = 1; m_starve[k] = 0; e_op[k] = REG_OP_NOP;
                for (int n = 0; n < 2; n++) begin
                    e_rv[k][n] = 1'b0; e_d1[k][n] = 8'h00; e_d2[k][n] = 8'h00;
                end
                for (int j = 0; j < 4; j++) m_reg[k][j] = 8'h00;
            end else begin
                was_free = !m_busy[k];
                e_rv[k][0] = 1'b0; e_rv[k][1] = 1'b0; e_op[k] = REG_OP_NOP;
                if (m_busy[k] && cyc == m_acc[k] + 1) begin
                    e_rv[k][m_gid[k]] = 1'b1;
                    e_d1[k][m_gid[k]] = m_reg[k][m_cs1[k]];
                    e_d2[k][m_gid[k]] = m_reg[k][m_cs2[k]];
                    if (m_cop[k] == REG_OP_WRITE) m_reg[k][m_cs1[k]] = m_cd[k];
                    else if (m_cop[k] == REG_OP_ADD) m_reg[k][m_cs1[k]] = m_reg[k][m_cs1[k]] + m_cd[k];
                end else if (m_busy[k] && cyc == m_acc[k] + 2) begin
                    m_busy[k] = 1'b0;
                end
                if (was_free && (v0 || v1)) begin
                    if (v0 && v1) g = (k == 0) ? (m_last[k] == 0 ? 1 : 0) : (m_starve[k] == 4 ? 1 : 0);
                    else g = v1 ? 1 : 0;
                    if (g == 1 || !v1) m_starve[k] = 0;
                    else if (m_starve[k] < 4) m_starve[k] = m_starve[k] + 1;
                    m_last[k] = g; m_gid[k] = g; m_acc[k] = cyc; m_busy[k] = 1'b1;
                    m_cop[k] = g ? op1 : op0;
                    m_cs1[k] = g ? int'(a1) : int'(a0);
                    m_cs2[k] = g ? int'(b1) : int'(b0);
                    m_cd[k]  = g ? wd1 : wd0;
                    e_op[k]  = m_cop[k];
                end
            end
        end
        m_init = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clock) begin
        if (m_init) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("k%0d_ready0", k), 32'(rdy0[k]), 32'(!m_busy[k] && !reset));
                chk($sformatf("k%0d_ready1", k), 32'(rdy1[k]), 32'(!m_busy[k] && !reset));
                chk($sformatf("k%0d_rsp0_valid", k), 32'(rv0[k]), 32'(e_rv[k][0]));
                chk($sformatf("k%0d_rsp1_valid", k), 32'(rv1[k]), 32'(e_rv[k][1]));
                chk($sformatf("k%0d_rsp0_data1", k), 32'(r0d1[k]), 32'(e_d1[k][0]));
                chk($sformatf("k%0d_rsp0_data2", k), 32'(r0d2[k]), 32'(e_d2[k][0]));
                chk($sformatf("k%0d_rsp1_data1", k), 32'(r1d1[k]), 32'(e_d1[k][1]));
                chk($sformatf("k%0d_rsp1_data2", k), 32'(r1d2[k]), 32'(e_d2[k][1]));
                chk($sformatf("k%0d_op", k), 32'(d_op[k]), 32'(e_op[k]));
                for (int j = 0; j < 4; j++)
                    chk($sformatf("k%0d_reg%0d", k, j), 32'(rf[k][j]), 32'(m_reg[k][j]));
            end
            if (rv0[0]) log_rr.push_back(0);
            if (rv1[0]) log_rr.push_back(1);
            if (rv0[1]) log_fp.push_back(0);
            if (rv1[1]) log_fp.push_back(1);
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    // Offers one command and returns in the EXEC cycle with valid dropped.
    task automatic send(input int id, input registers_op_e o, input register_sel_e s1,
                        input register_sel_e s2, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        if (id == 0) begin v0 = 1'b1; op0 = o; a0 = s1; b0 = s2; wd0 = d; end
        else begin v1 = 1'b1; op1 = o; a1 = s1; b1 = s2; wd1 = d; end
        for (int n = 0; n < 20 && !ok; n++) begin
            if ((id == 0 && rdy0[0]) || (id == 1 && rdy1[0])) begin
                ok = 1'b1;
                @(posedge clock);
            end else begin
                step();
            end
        end
        step();
        v0 = 1'b0; v1 = 1'b0;
        chk("send_accepted", 32'(ok), 32'd1);
    endtask

    initial begin
        repeat (3) step();
        chk("reset_ready0", 32'(rdy0[0]), 32'd0);
        reset = 1'b0;
        step();
        chk("reset_ready0_after", 32'(rdy0[0]), 32'd1);
        chk("reset_op", 32'(d_op[0]), 32'(REG_OP_NOP));
        chk("reset_rsp0_data1", 32'(r0d1[0]), 32'h0);

        // Write R2=0x5A, read it back, then an add that must return the pre-write value.
        send(0, REG_OP_WRITE, REG_R2, REG_R0, 8'h5A); step(); step();
        send(0, REG_OP_READ, REG_R2, REG_R3, 8'h00);
        chk("t1_exec_no_rsp", 32'(rv0[0]), 32'd0);
        step();
        chk("t1_rsp0_valid", 32'(rv0[0]), 32'd1);
        chk("t1_rsp0_data1", 32'(r0d1[0]), 32'h5A);
        chk("t1_fp_rsp0_data1", 32'(r0d1[1]), 32'h5A);
        step();
        send(0, REG_OP_ADD, REG_R2, REG_R2, 8'h01); step();
        chk("t1_add_prewrite", 32'(r0d1[0]), 32'h5A);
        chk("t1_add_result", 32'(rf[0][2]), 32'h5B);
        step();

        // Host writes R1/R2 and reads both back.
        send(1, REG_OP_WRITE, REG_R1, REG_R0, 8'h11); step(); step();
        send(1, REG_OP_WRITE, REG_R2, REG_R0, 8'h22); step(); step();
        send(1, REG_OP_READ, REG_R1, REG_R2, 8'h00); step();
        chk("t5_rsp1_valid", 32'(rv1[0]), 32'd1);
        chk("t5_rsp0_valid", 32'(rv0[0]), 32'd0);
        chk("t5_rsp1_data1", 32'(r1d1[0]), 32'h11);
        chk("t5_rsp1_data2", 32'(r1d2[0]), 32'h22);
        step();

        // Both requesters continuously valid.
        log_rr.delete(); log_fp.delete();
        v0 = 1'b1; v1 = 1'b1; op0 = REG_OP_READ; op1 = REG_OP_READ;
        repeat (20) step();
        v0 = 1'b0; v1 = 1'b0;
        repeat (4) step();
        chk("t2_rr_count", 32'(log_rr.size() >= 4), 32'd1);
        chk("t3_fp_count", 32'(log_fp.size() >= 6), 32'd1);
        if (log_rr.size() >= 4) begin
            chk("t2_rr_g0", 32'(log_rr[0]), 32'd0); chk("t2_rr_g1", 32'(log_rr[1]), 32'd1);
            chk("t2_rr_g2", 32'(log_rr[2]), 32'd0); chk("t2_rr_g3", 32'(log_rr[3]), 32'd1);
        end
        if (log_fp.size() >= 6) begin
            chk("t3_fp_g3", 32'(log_fp[3]), 32'd0);
            chk("t3_fp_g4", 32'(log_fp[4]), 32'd1);
            chk("t3_fp_g5", 32'(log_fp[5]), 32'd0);
        end

        // Reset while a write of R3=0xFF sits in EXEC.
        send(0, REG_OP_WRITE, REG_R3, REG_R0, 8'hFF);
        reset = 1'b1;
        step();
        chk("t4_no_rsp", 32'(rv0[0]), 32'd0);
        reset = 1'b0;
        step();
        chk("t4_ready", 32'(rdy0[0]), 32'd1);
        chk("t4_r3_kept", 32'(rf[0][3]), 32'h00);
        chk("t4_still_no_rsp", 32'(rv0[0]), 32'd0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            v0  = ($urandom_range(0, 9) < 7);
            v1  = ($urandom_range(0, 9) < 6);
            op0 = registers_op_e'($urandom_range(0, 3));
            op1 = registers_op_e'($urandom_range(0, 3));
            a0  = register_sel_e'($urandom_range(0, 3));
            b0  = register_sel_e'($urandom_range(0, 3));
            a1  = register_sel_e'($urandom_range(0, 3));
            b1  = register_sel_e'($urandom_range(0, 3));
            wd0 = 8'($urandom);
            wd1 = 8'($urandom);
            step();
        end
        reset = 1'b0; v0 = 1'b0; v1 = 1'b0;
        repeat (5) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
